// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: OAM DMA state encoding and register constants.
package ppu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } dma_state_t;

   localparam logic [15:0] OAM_DMA_REG = 16'h4014;
   localparam int          OAM_SIZE    = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA engine: halts the CPU and copies one page of CPU memory into PPU OAM,
// alternating get (read) and put (write) CPU cycles.
import ppu_pkg::*;

module oam_dma_ctrl #(
   parameter int DMA_LEN = OAM_SIZE
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_ce,
   input  logic        reg_wr,
   input  logic [7:0]  cpu_data_in,
   input  logic [7:0]  oam_base,
   input  logic [7:0]  bus_data_in,
   output logic        cpu_halt,
   output logic        bus_rd,
   output logic [15:0] bus_addr,
   output logic        oam_dma,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_data_in,
   output logic        dma_busy
);

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

   dma_state_t  state_q, state_d;
   logic        get_cyc_q, get_cyc_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  base_q, base_d;
   logic [7:0]  idx_q, idx_d;
   logic        halt_q, halt_d;
   logic        bus_rd_q, bus_rd_d;
   logic [15:0] bus_addr_q, bus_addr_d;
   logic [7:0]  oam_addr_q, oam_addr_d;
   logic [7:0]  oam_data_q, oam_data_d;

   // Next-state, counters and registered-output values; nothing moves without cpu_ce.
   always_comb begin
      state_d    = state_q;
      get_cyc_d  = get_cyc_q;
      page_d     = page_q;
      base_d     = base_q;
      idx_d      = idx_q;
      oam_addr_d = oam_addr_q;
      oam_data_d = oam_data_q;

      if (cpu_ce) begin
         get_cyc_d = ~get_cyc_q;
         case (state_q)
            IDLE: begin
               if (reg_wr) begin
                  page_d  = cpu_data_in;
                  base_d  = oam_base;
                  idx_d   = 8'h00;
                  state_d = HALT;
               end else begin
                  state_d = IDLE;
               end
            end
            // A current get cycle means the next one is a put, so one extra dummy cycle is needed.
            HALT:  state_d = get_cyc_q ? ALIGN : READ;
            ALIGN: state_d = READ;
            READ: begin
               oam_data_d = bus_data_in;
               oam_addr_d = base_q + idx_q;
               state_d    = WRITE;
            end
            WRITE: begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = READ;
               end
            end
            default: state_d = IDLE;
         endcase
      end else begin
         get_cyc_d = get_cyc_q;
      end

      halt_d   = (state_d != IDLE);
      bus_rd_d = (state_d == READ);
      if (state_d == READ) begin
         bus_addr_d = {page_d, idx_d};
      end else begin
         bus_addr_d = bus_addr_q;
      end
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         get_cyc_q  <= 1'b1;
         page_q     <= 8'h00;
         base_q     <= 8'h00;
         idx_q      <= 8'h00;
         halt_q     <= 1'b0;
         bus_rd_q   <= 1'b0;
         bus_addr_q <= 16'h0000;
         oam_addr_q <= 8'h00;
         oam_data_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         get_cyc_q  <= get_cyc_d;
         page_q     <= page_d;
         base_q     <= base_d;
         idx_q      <= idx_d;
         halt_q     <= halt_d;
         bus_rd_q   <= bus_rd_d;
         bus_addr_q <= bus_addr_d;
         oam_addr_q <= oam_addr_d;
         oam_data_q <= oam_data_d;
      end
   end

   assign cpu_halt    = halt_q;
   assign dma_busy    = halt_q;
   assign bus_rd      = bus_rd_q;
   assign bus_addr    = bus_addr_q;
   assign oam_addr    = oam_addr_q;
   assign oam_data_in = oam_data_q;
   // Strobe lasts only for the clk of the cpu_ce edge that ends the WRITE cycle.
   assign oam_dma     = (state_q == WRITE) & cpu_ce;

endmodule
